wb_register_file: RTL and testbench

- Architectural register file at the consumer end of the load/store writeback interface.
- Accepts the two writeback lanes (A, B) of enable/address/data and serves four registered read ports to the operand-fetch stage.
- Holds a per-register pending scoreboard: set when a lane issues a destination, cleared by the matching writeback.
- Provides same-cycle write bypass and a saturating counter of A/B collisions.

---
 rtl/wb_register_file.sv | 130 +++++++++++++
 tb/tb_wb_register_file.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_register_file.sv
// Architectural register file with dual writeback lanes, pending scoreboard,
// same-cycle write bypass, four registered read ports and collision counter.
module wb_register_file #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 8
) (
    input  logic              clock_i,
    input  logic              resetn_i,
    input  logic              wbEnableA_i,
    input  logic [ADDR_W-1:0] wbAddressA_i,
    input  logic [DATA_W-1:0] wbDataA_i,
    input  logic              wbEnableB_i,
    input  logic [ADDR_W-1:0] wbAddressB_i,
    input  logic [DATA_W-1:0] wbDataB_i,
    input  logic              issueEnableA_i,
    input  logic [ADDR_W-1:0] issueDestA_i,
    input  logic              issueEnableB_i,
    input  logic [ADDR_W-1:0] issueDestB_i,
    input  logic [ADDR_W-1:0] rdAddrA0_i,
    input  logic [ADDR_W-1:0] rdAddrA1_i,
    input  logic [ADDR_W-1:0] rdAddrB0_i,
    input  logic [ADDR_W-1:0] rdAddrB1_i,
    output logic [DATA_W-1:0] rdDataA0_o,
    output logic [DATA_W-1:0] rdDataA1_o,
    output logic [DATA_W-1:0] rdDataB0_o,
    output logic [DATA_W-1:0] rdDataB1_o,
    output logic              rdReadyA0_o,
    output logic              rdReadyA1_o,
    output logic              rdReadyB0_o,
    output logic              rdReadyB1_o,
    output logic              collision_o,
    output logic [CNT_W-1:0]  collisionCount_o
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic                wr_a;
    logic                wr_b;
    logic                coll_now;
    logic [ADDR_W-1:0]   rd_addr [4];
    logic [DATA_W-1:0]   rd_nxt  [4];
    logic                rdy_nxt [4];
    logic [DATA_W-1:0]   rd_q    [4];
    logic                rdy_q   [4];

    assign wr_a     = wbEnableA_i && (wbAddressA_i != '0);
    assign wr_b     = wbEnableB_i && (wbAddressB_i != '0);
    assign coll_now = wr_a && wr_b && (wbAddressA_i == wbAddressB_i);

    assign rd_addr[0] = rdAddrA0_i;
    assign rd_addr[1] = rdAddrA1_i;
    assign rd_addr[2] = rdAddrB0_i;
    assign rd_addr[3] = rdAddrB1_i;

    // Scoreboard: issue sets, writeback clears, issue wins; r0 never pending.
    always_comb begin
        pending_nxt = pending;
        for (int r = 1; r < NUM_REGS; r++) begin
            if ((wbEnableA_i && wbAddressA_i == ADDR_W'(r)) ||
                (wbEnableB_i && wbAddressB_i == ADDR_W'(r)))
                pending_nxt[r] = 1'b0;
            if ((issueEnableA_i && issueDestA_i == ADDR_W'(r)) ||
                (issueEnableB_i && issueDestB_i == ADDR_W'(r)))
                pending_nxt[r] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Read data with write bypass (B younger than A) and next-cycle readiness.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rd_nxt[p] = regs[rd_addr[p]];
            if (wr_a && wbAddressA_i == rd_addr[p])
                rd_nxt[p] = wbDataA_i;
            if (wr_b && wbAddressB_i == rd_addr[p])
                rd_nxt[p] = wbDataB_i;
            if (rd_addr[p] == '0)
                rd_nxt[p] = '0;
            rdy_nxt[p] = ~pending_nxt[rd_addr[p]];
        end
    end

    // Register storage; lane B is applied last so it wins a collision.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
        end else begin
            if (wr_a)
                regs[wbAddressA_i] <= wbDataA_i;
            if (wr_b)
                regs[wbAddressB_i] <= wbDataB_i;
        end
    end

    // Scoreboard state, read port registers and collision tracking.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pending          <= '0;
            collision_o      <= 1'b0;
            collisionCount_o <= '0;
            for (int p = 0; p < 4; p++) begin
                rd_q[p]  <= '0;
                rdy_q[p] <= 1'b0;
            end
        end else begin
            pending     <= pending_nxt;
            collision_o <= coll_now;
            if (coll_now && collisionCount_o != '1)
                collisionCount_o <= collisionCount_o + 1'b1;
            for (int p = 0; p < 4; p++) begin
                rd_q[p]  <= rd_nxt[p];
                rdy_q[p] <= rdy_nxt[p];
            end
        end
    end

    assign rdDataA0_o  = rd_q[0];
    assign rdDataA1_o  = rd_q[1];
    assign rdDataB0_o  = rd_q[2];
    assign rdDataB1_o  = rd_q[3];
    assign rdReadyA0_o = rdy_q[0];
    assign rdReadyA1_o = rdy_q[1];
    assign rdReadyB0_o = rdy_q[2];
    assign rdReadyB1_o = rdy_q[3];

endmodule

// File: tb/tb_wb_register_file.sv
// Bench for wb_register_file: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_wb_register_file;

    logic        clk;
    logic        rstn;
    logic        wb_en_a, wb_en_b;
    logic [4:0]  wb_ad_a, wb_ad_b;
    logic [15:0] wb_d_a, wb_d_b;
    logic        is_en_a, is_en_b;
    logic [4:0]  is_d_a, is_d_b;
    logic [4:0]  ra [4];
    logic [15:0] rd [4];
    logic        rr [4];
    logic        coll;
    logic [7:0]  cnt;

    int          vectors = 0;
    int          miscompares = 0;

    logic [15:0] m_regs [32];
    bit          m_pend [32];
    int          m_cnt;
    bit          m_coll;

    wb_register_file dut (
        .clock_i(clk), .resetn_i(rstn),
        .wbEnableA_i(wb_en_a), .wbAddressA_i(wb_ad_a), .wbDataA_i(wb_d_a),
        .wbEnableB_i(wb_en_b), .wbAddressB_i(wb_ad_b), .wbDataB_i(wb_d_b),
        .issueEnableA_i(is_en_a), .issueDestA_i(is_d_a),
        .issueEnableB_i(is_en_b), .issueDestB_i(is_d_b),
        .rdAddrA0_i(ra[0]), .rdAddrA1_i(ra[1]),
        .rdAddrB0_i(ra[2]), .rdAddrB1_i(ra[3]),
        .rdDataA0_o(rd[0]), .rdDataA1_o(rd[1]),
        .rdDataB0_o(rd[2]), .rdDataB1_o(rd[3]),
        .rdReadyA0_o(rr[0]), .rdReadyA1_o(rr[1]),
        .rdReadyB0_o(rr[2]), .rdReadyB1_o(rr[3]),
        .collision_o(coll), .collisionCount_o(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wb_en_a = 0; wb_ad_a = 0; wb_d_a = 0;
        wb_en_b = 0; wb_ad_b = 0; wb_d_b = 0;
        is_en_a = 0; is_d_a = 0;
        is_en_b = 0; is_d_b = 0;
        for (int p = 0; p < 4; p++) ra[p] = 0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 0;
            m_pend[r] = 0;
        end
        m_cnt  = 0;
        m_coll = 0;
    endtask

    task automatic chk_all_zero(string tag);
        for (int p = 0; p < 4; p++) begin
            chk({tag, "_data"}, 32'(rd[p]), 0);
            chk({tag, "_ready"}, 32'(rr[p]), 0);
        end
        chk({tag, "_coll"}, 32'(coll), 0);
        chk({tag, "_cnt"}, 32'(cnt), 0);
    endtask

    // One clock cycle: predict from the model, clock, update model, compare.
    task automatic step();
        bit          pn [32];
        logic [15:0] ed [4];
        bit          er [4];
        bit          c;
        for (int r = 0; r < 32; r++) begin
            pn[r] = m_pend[r];
            if (wb_en_a && wb_ad_a == r) pn[r] = 0;
            if (wb_en_b && wb_ad_b == r) pn[r] = 0;
            if (is_en_a && is_d_a == r) pn[r] = 1;
            if (is_en_b && is_d_b == r) pn[r] = 1;
        end
        pn[0] = 0;
        for (int p = 0; p < 4; p++) begin
            if (ra[p] == 0) ed[p] = 0;
            else if (wb_en_b && wb_ad_b == ra[p]) ed[p] = wb_d_b;
            else if (wb_en_a && wb_ad_a == ra[p]) ed[p] = wb_d_a;
            else ed[p] = m_regs[ra[p]];
            er[p] = !pn[ra[p]];
        end
        c = wb_en_a && wb_en_b && wb_ad_a == wb_ad_b && wb_ad_a != 0;
        @(posedge clk);
        #1;
        if (wb_en_a && wb_ad_a != 0) m_regs[wb_ad_a] = wb_d_a;
        if (wb_en_b && wb_ad_b != 0) m_regs[wb_ad_b] = wb_d_b;
        for (int r = 0; r < 32; r++) m_pend[r] = pn[r];
        m_coll = c;
        if (c && m_cnt < 255) m_cnt++;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("rd_data%0d", p), 32'(rd[p]), 32'(ed[p]));
            chk($sformatf("rd_ready%0d", p), 32'(rr[p]), 32'(er[p]));
        end
        chk("collision", 32'(coll), 32'(m_coll));
        chk("coll_count", 32'(cnt), 32'(m_cnt));
    endtask

    task automatic read_all(logic [4:0] a);
        for (int p = 0; p < 4; p++) ra[p] = a;
    endtask

    initial begin
        rstn = 0;
        idle();
        model_reset();
        #1;
        chk_all_zero("reset_init");
        #12;
        rstn = 1;
        @(posedge clk); #1;

        // write r5 then reset mid-run
        idle(); wb_en_a = 1; wb_ad_a = 5; wb_d_a = 16'h1234; read_all(5);
        step();
        chk("r5_written", 32'(rd[0]), 32'h1234);
        idle(); read_all(5);
        #2 rstn = 0;
        #1;
        model_reset();
        chk_all_zero("reset_mid");
        #3 rstn = 1;
        step();
        chk("r5_after_reset", 32'(rd[0]), 0);
        chk("r5_ready_after_reset", 32'(rr[0]), 1);

        // issue then writeback r3
        idle(); is_en_a = 1; is_d_a = 3;
        step();
        idle(); read_all(3);
        step();
        chk("r3_pending", 32'(rr[1]), 0);
        idle(); wb_en_a = 1; wb_ad_a = 3; wb_d_a = 16'hBEEF; read_all(3);
        step();
        chk("r3_bypass", 32'(rd[2]), 32'hBEEF);
        chk("r3_ready", 32'(rr[2]), 1);

        // lane collision on r7
        idle(); wb_en_a = 1; wb_ad_a = 7; wb_d_a = 16'h1111;
        wb_en_b = 1; wb_ad_b = 7; wb_d_b = 16'h2222; read_all(7);
        step();
        chk("r7_b_wins", 32'(rd[0]), 32'h2222);
        chk("coll_pulse", 32'(coll), 1);
        chk("coll_cnt1", 32'(cnt), 1);
        idle(); read_all(7);
        step();
        chk("coll_drop", 32'(coll), 0);
        chk("r7_stored", 32'(rd[3]), 32'h2222);
        for (int i = 0; i < 300; i++) begin
            idle(); wb_en_a = 1; wb_ad_a = 7; wb_d_a = 16'(i);
            wb_en_b = 1; wb_ad_b = 7; wb_d_b = 16'(i + 1000);
            step();
        end
        chk("coll_saturate", 32'(cnt), 255);

        // issue beats same-cycle writeback
        idle(); is_en_b = 1; is_d_b = 9;
        wb_en_a = 1; wb_ad_a = 9; wb_d_a = 16'h00AA; read_all(9);
        step();
        chk("r9_data", 32'(rd[1]), 32'h00AA);
        chk("r9_pending", 32'(rr[1]), 0);

        // register zero
        idle(); wb_en_b = 1; wb_ad_b = 0; wb_d_b = 16'hFFFF;
        is_en_a = 1; is_d_a = 0; read_all(0);
        step();
        chk("r0_data", 32'(rd[0]), 0);
        chk("r0_ready", 32'(rr[0]), 1);
        idle(); wb_en_a = 1; wb_ad_a = 0; wb_d_a = 16'h0101;
        wb_en_b = 1; wb_ad_b = 0; wb_d_b = 16'h0202;
        step();
        chk("r0_no_coll", 32'(coll), 0);

        // four-port alias
        idle(); wb_en_b = 1; wb_ad_b = 12; wb_d_b = 16'h5A5A; read_all(12);
        step();
        for (int p = 0; p < 4; p++)
            chk($sformatf("alias%0d", p), 32'(rd[p]), 32'h5A5A);

        // random traffic on a narrow address range for frequent aliasing
        for (int i = 0; i < 400; i++) begin
            wb_en_a = 1'($urandom);
            wb_ad_a = 5'($urandom_range(0, 7));
            wb_d_a  = 16'($urandom);
            wb_en_b = 1'($urandom);
            wb_ad_b = 5'($urandom_range(0, 7));
            wb_d_b  = 16'($urandom);
            is_en_a = ($urandom_range(0, 3) == 0);
            is_d_a  = 5'($urandom_range(0, 7));
            is_en_b = ($urandom_range(0, 3) == 0);
            is_d_b  = 5'($urandom_range(0, 7));
            for (int p = 0; p < 4; p++)
                ra[p] = 5'($urandom_range(0, 8));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
